// File: rtl/crc_param_responder.sv
// crc_param_responder: far end of the CRC engine parameter request channel.
// Buffers requests in a small FIFO, looks each one up in a 16-entry
// polynomial/init table after LATENCY wait cycles, and returns one response
// per request in order.
// Optional build macro: CRC_PARAM_ERR_CNT_EN (saturating error-response counter).
module crc_param_responder #(
  parameter int unsigned CRC_PARAM_REQ_WITDH = 24,
  parameter int unsigned CRC_PARAM_RSP_WITDH = 73,
  parameter int unsigned FIFO_DEPTH          = 4,
  parameter int unsigned LATENCY             = 2
) (
  input  logic                           i_clk,
  input  logic                           i_nreset,
  input  logic                           i_crc_param_valid,
  input  logic [CRC_PARAM_REQ_WITDH-1:0] i_crc_param_data,
  output logic                           o_crc_param_ready,
  output logic                           o_crc_param_done_valid,
  output logic [CRC_PARAM_RSP_WITDH-1:0] o_crc_param_done_data,
  input  logic                           i_crc_param_done_ready,
  input  logic                           i_tbl_wr_en,
  input  logic [3:0]                     i_tbl_wr_idx,
  input  logic [31:0]                    i_tbl_wr_poly,
  input  logic [31:0]                    i_tbl_wr_init,
  output logic                           o_busy,
  output logic [7:0]                     o_err_cnt
);

  localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W      = PTR_W + 1;
  localparam int unsigned CNT_W       = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam int unsigned TBL_N       = 16;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned TAG_W       = 8;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned IDX_LSB     = TAG_W;
  localparam int unsigned RSVD_LSB    = TAG_W + IDX_W;
  localparam int unsigned RSP_ERR_BIT = 2 * WORD_W + TAG_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // After a pop the FSM either waits out the lookup latency or responds at once.
  localparam state_t POP_STATE = (LATENCY == 0) ? S_RESP : S_WAIT;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [CRC_PARAM_REQ_WITDH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]               wr_ptr_q;
  logic [PTR_W-1:0]               rd_ptr_q;
  logic [FCNT_W-1:0]              count_q;
  logic [FCNT_W-1:0]              count_d;
  logic                           ready_q;
  logic                           push;
  logic                           pop;
  logic                           fifo_empty;
  logic [CRC_PARAM_REQ_WITDH-1:0] head;
  logic [TAG_W-1:0]               head_tag;
  logic [IDX_W-1:0]               head_idx;
  logic                           unused_rsvd;

  assign push       = i_crc_param_valid && ready_q;
  assign fifo_empty = (count_q == '0);
  assign count_d    = count_q + FCNT_W'(push) - FCNT_W'(pop);
  assign head       = fifo_mem[rd_ptr_q];
  assign head_tag   = head[TAG_W-1:0];
  assign head_idx   = head[IDX_LSB +: IDX_W];
  // Reserved request bits travel through the FIFO but carry no meaning here.
  assign unused_rsvd = ^head[CRC_PARAM_REQ_WITDH-1:RSVD_LSB];

  // FIFO storage: whole request captured on push, no reset needed.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= i_crc_param_data;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ready_q <= (count_d != FCNT_W'(FIFO_DEPTH));
    end
  end

  // ---------------------------------------------------------------------------
  // Parameter table
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] tbl_poly [TBL_N];
  logic [WORD_W-1:0] tbl_init [TBL_N];
  logic [TBL_N-1:0]  tbl_vld_q;
  logic              snap_vld;
  logic [CRC_PARAM_RSP_WITDH-1:0] rsp_next;

  // Table contents: don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (i_tbl_wr_en) begin
      tbl_poly[i_tbl_wr_idx] <= i_tbl_wr_poly;
      tbl_init[i_tbl_wr_idx] <= i_tbl_wr_init;
    end
  end

  // Per-entry valid bits; only reset clears them.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      tbl_vld_q <= '0;
    end else if (i_tbl_wr_en) begin
      tbl_vld_q[i_tbl_wr_idx] <= 1'b1;
    end
  end

  // Snapshot of the head entry; a same-cycle write lands after this is latched.
  assign snap_vld = tbl_vld_q[head_idx];
  assign rsp_next = CRC_PARAM_RSP_WITDH'({~snap_vld,
                                          snap_vld ? tbl_init[head_idx] : WORD_W'(0),
                                          snap_vld ? tbl_poly[head_idx] : WORD_W'(0),
                                          head_tag});

  // ---------------------------------------------------------------------------
  // Lookup / response FSM
  // ---------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // FSM state and wait counter registers.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: pop on idle or on response handshake, then wait LATENCY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cnt_d   = CNT_W'(LATENCY);
          state_d = POP_STATE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (i_crc_param_done_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            cnt_d   = CNT_W'(LATENCY);
            state_d = POP_STATE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered response and status outputs
  // ---------------------------------------------------------------------------
  logic                           done_valid_q;
  logic [CRC_PARAM_RSP_WITDH-1:0] rsp_q;
  logic                           busy_q;

  // Response payload is loaded at pop and held until the next pop.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      done_valid_q <= 1'b0;
      rsp_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      if (pop) rsp_q <= rsp_next;
      done_valid_q <= (state_d == S_RESP);
      busy_q       <= (count_d != '0) || (state_d != S_IDLE);
    end
  end

  assign o_crc_param_ready      = ready_q;
  assign o_crc_param_done_valid = done_valid_q;
  assign o_crc_param_done_data  = rsp_q;
  assign o_busy                 = busy_q;

`ifdef CRC_PARAM_ERR_CNT_EN
  logic       rsp_hs;
  logic [7:0] err_cnt_q;

  assign rsp_hs = done_valid_q && i_crc_param_done_ready;

  // Saturating count of handshaken error responses.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      err_cnt_q <= '0;
    end else if (rsp_hs && rsp_q[RSP_ERR_BIT] && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign o_err_cnt = err_cnt_q;
`else
  assign o_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_crc_param_responder.sv
// Scoreboard bench for crc_param_responder: expected responses are queued at
// request acceptance from a table model and compared by an independent monitor.
module tb_crc_param_responder;

  localparam int unsigned REQ_W = 24;
  localparam int unsigned RSP_W = 73;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 2;
`ifdef CRC_PARAM_ERR_CNT_EN
  localparam int unsigned SAT_CNT = 255;
`else
  localparam int unsigned SAT_CNT = 0;
`endif

  typedef logic [RSP_W-1:0] rsp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid;
  logic [REQ_W-1:0] req_data;
  logic             req_ready;
  logic             done_valid;
  rsp_t             done_data;
  logic             done_ready;
  logic             wr_en;
  logic [3:0]       wr_idx;
  logic [31:0]      wr_poly;
  logic [31:0]      wr_init;
  logic             busy;
  logic [7:0]       err_cnt;

  crc_param_responder #(
    .CRC_PARAM_REQ_WITDH(REQ_W),
    .CRC_PARAM_RSP_WITDH(RSP_W),
    .FIFO_DEPTH(DEPTH),
    .LATENCY(LAT)
  ) dut (
    .i_clk(clk),
    .i_nreset(rst_n),
    .i_crc_param_valid(req_valid),
    .i_crc_param_data(req_data),
    .o_crc_param_ready(req_ready),
    .o_crc_param_done_valid(done_valid),
    .o_crc_param_done_data(done_data),
    .i_crc_param_done_ready(done_ready),
    .i_tbl_wr_en(wr_en),
    .i_tbl_wr_idx(wr_idx),
    .i_tbl_wr_poly(wr_poly),
    .i_tbl_wr_init(wr_init),
    .o_busy(busy),
    .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference state
  rsp_t        exp_q[$];
  logic [31:0] m_poly [16];
  logic [31:0] m_init [16];
  logic        m_vld  [16];
  int          checks = 0;
  int          errors = 0;
  logic        rnd_ready = 1'b0;
  logic        ready_hold = 1'b1;
  logic        stalled = 1'b0;
  rsp_t        held;

  task automatic check(input string name, input rsp_t act, input rsp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic rsp_t model_rsp(input logic [7:0] tag, input int idx);
    if (!m_vld[idx]) return {1'b1, 32'd0, 32'd0, tag};
    return {1'b0, m_init[idx], m_poly[idx], tag};
  endfunction

  // Response-ready driver: random in the soak phase, otherwise held level.
  always @(posedge clk) begin
    #2;
    done_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
  end

  // Monitor: compare each handshaken response and check stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("valid_held_under_stall", rsp_t'(done_valid), rsp_t'(1));
        if (done_valid) check("data_stable_under_stall", done_data, held);
      end
      if (done_valid && done_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got 0x%0h expected none", done_data);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp", done_data, e);
        end
      end
      stalled = done_valid && !done_ready;
      held    = done_data;
    end
  end

  task automatic send(input logic [7:0] tag, input int idx);
    int n;
    logic [11:0] rsvd;
    rsvd      = 12'($urandom);
    req_data  = {rsvd, 4'(idx), tag};
    req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(model_rsp(tag, idx));
        break;
      end
      n++;
      if (n >= 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: tag 0x%0h never accepted", tag);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] poly, input logic [31:0] init);
    wr_en   = 1'b1;
    wr_idx  = 4'(idx);
    wr_poly = poly;
    wr_init = init;
    @(posedge clk);
    #1;
    wr_en       = 1'b0;
    m_poly[idx] = poly;
    m_init[idx] = init;
    m_vld[idx]  = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy || done_valid) && n < 3000);
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: pending %0d busy %0b", exp_q.size(), busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tagname);
    check({tagname, "_ready"},      rsp_t'(req_ready),  rsp_t'(1));
    check({tagname, "_done_valid"}, rsp_t'(done_valid), rsp_t'(0));
    check({tagname, "_done_data"},  done_data,          rsp_t'(0));
    check({tagname, "_busy"},       rsp_t'(busy),       rsp_t'(0));
    check({tagname, "_err_cnt"},    rsp_t'(err_cnt),    rsp_t'(0));
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic seen;
    req_valid  = 1'b0;
    req_data   = '0;
    done_ready = 1'b1;
    wr_en      = 1'b0;
    wr_idx     = '0;
    wr_poly    = '0;
    wr_init    = '0;
    for (int i = 0; i < 16; i++) begin
      m_vld[i]  = 1'b0;
      m_poly[i] = '0;
      m_init[i] = '0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unprogrammed entry returns an error response
    send(8'h01, 7);
    wait_idle();
    check("err_cnt_after_unprogrammed", rsp_t'(err_cnt), rsp_t'(SAT_CNT == 0 ? 0 : 1));

    // Basic lookup and lone-request latency
    wr(3, 32'h04C11DB7, 32'hFFFFFFFF);
    send(8'h5A, 3);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done_valid && k < 50);
    check("lone_latency", rsp_t'(k), rsp_t'(2 + LAT));
    wait_idle();

    // Write/lookup collision on the pop cycle
    wr(2, 32'hAAAA0001, 32'hAAAA0002);
    wait_idle();
    send(8'h22, 2);
    wr(2, 32'hBBBB0001, 32'hBBBB0002);
    wait_idle();
    send(8'h23, 2);
    wait_idle();

    // Backpressure and full FIFO
    ready_hold = 1'b0;
    @(posedge clk);
    #1;
    for (int t = 0; t < 5; t++) send(8'(t), 3);
    @(negedge clk);
    check("ready_low_when_full", rsp_t'(req_ready), rsp_t'(0));
    repeat (5) @(posedge clk);
    #1;
    ready_hold = 1'b1;
    send(8'h05, 3);
    wait_idle();

    // Randomized soak
    rnd_ready = 1'b1;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        wait_idle();
        wr(int'($urandom_range(0, 15)), $urandom, $urandom);
      end
      send(8'($urandom), int'($urandom_range(0, 15)));
    end
    wait_idle();
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset while responding with requests queued
    ready_hold = 1'b0;
    @(posedge clk);
    #1;
    send(8'h30, 3);
    send(8'h31, 3);
    send(8'h32, 3);
    k = 0;
    while (!done_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("resp_before_reset", rsp_t'(done_valid), rsp_t'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_hold = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done_valid) seen = 1'b1;
    end
    check("no_rsp_after_reset", rsp_t'(seen), rsp_t'(0));
    @(posedge clk);
    #1;
    send(8'h77, 3);
    wait_idle();

    // Error counter saturation
    for (int i = 0; i < 300; i++) send(8'(i), 9);
    wait_idle();
    check("err_cnt_saturation", rsp_t'(err_cnt), rsp_t'(SAT_CNT));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
